custom_ip_reg_bank: RTL and testbench

//  Parametrised register-to-IP bridge between the AXI register file and a custom accelerator core.

---
 rtl/custom_ip_pkg.sv | 18 +
 rtl/custom_ip_reg_chan.sv | 90 +++++++++
 rtl/custom_ip_reg_bank.sv | 60 ++++++
 tb/tb_custom_ip_reg_bank.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/custom_ip_pkg.sv
// Shared types and limits for the custom IP register bank.
// Holds the ack-mode selector, the per-channel handshake state encoding and the parameter ceilings.
package custom_ip_pkg;

   typedef enum logic {
      ACK_HANDSHAKE = 1'b0,
      ACK_PULSE     = 1'b1
   } ack_mode_e;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_PENDING = 1'b1
   } pend_state_e;

   localparam int MAX_CH     = 32;
   localparam int MAX_DATA_W = 64;

endpackage

// File: rtl/custom_ip_reg_chan.sv
// One channel of the register bank: data register, IP handshake FSM, sticky overrun flag
// and a one-cycle read-back valid strobe.
module custom_ip_reg_chan
   import custom_ip_pkg::*;
#(
   parameter int                 DATA_W    = 32,
   parameter ack_mode_e          ACK_MODE  = ACK_HANDSHAKE,
   parameter logic [DATA_W-1:0]  RESET_VAL = '0
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [DATA_W-1:0] reg_wdata_i,
   input  logic              reg_we_i,
   input  logic [DATA_W-1:0] ip_wdata_i,
   input  logic              ip_we_i,
   input  logic              ip_ack_i,
   input  logic              ovf_clr_i,
   output logic [DATA_W-1:0] ch_o,
   output logic              rvalid_o,
   output logic              req_o,
   output logic              ovf_o
);

   logic [DATA_W-1:0] ch_d, ch_q;
   logic              rv_d, rv_q;
   logic              ovf_q;
   logic              ovf_set;
   pend_state_e       state_q;

   // Register-side writes win over IP-side writes; any accepted write raises read-back valid.
   always_comb begin
      ch_d = ch_q;
      rv_d = 1'b0;
      if (reg_we_i) begin
         ch_d = reg_wdata_i;
         rv_d = 1'b1;
      end else if (ip_we_i) begin
         ch_d = ip_wdata_i;
         rv_d = 1'b1;
      end else begin
         ch_d = ch_q;
         rv_d = 1'b0;
      end
   end

   // An overrun is a fresh register write landing on unconsumed data (handshake mode only).
   assign ovf_set = (ACK_MODE == ACK_HANDSHAKE) && (state_q == ST_PENDING) && reg_we_i && !ip_ack_i;

   // Data register and read-back valid strobe.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ch_q <= RESET_VAL;
         rv_q <= 1'b0;
      end else begin
         ch_q <= ch_d;
         rv_q <= rv_d;
      end
   end

   // Handshake FSM with sticky overrun; in pulse mode PENDING lasts exactly one cycle per write.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         ovf_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (reg_we_i) state_q <= ST_PENDING;
               else          state_q <= ST_IDLE;
            end
            ST_PENDING: begin
               if (ACK_MODE == ACK_PULSE) state_q <= reg_we_i ? ST_PENDING : ST_IDLE;
               else if (reg_we_i)         state_q <= ST_PENDING;
               else if (ip_ack_i)         state_q <= ST_IDLE;
               else                       state_q <= ST_PENDING;
            end
            default: state_q <= ST_IDLE;
         endcase
         if (ovf_set)        ovf_q <= 1'b1;
         else if (ovf_clr_i) ovf_q <= 1'b0;
         else                ovf_q <= ovf_q;
      end
   end

   assign ch_o     = ch_q;
   assign rvalid_o = rv_q;
   assign req_o    = (state_q == ST_PENDING);
   assign ovf_o    = ovf_q;

endmodule

// File: rtl/custom_ip_reg_bank.sv
// Register-to-IP bridge: NUM_CH independent channels written from the register file or the IP,
// with register-side updates delivered to the IP by req/ack (or a one-cycle req pulse).
module custom_ip_reg_bank
   import custom_ip_pkg::*;
#(
   parameter int                        NUM_CH    = 3,
   parameter int                        DATA_W    = 32,
   parameter ack_mode_e                 ACK_MODE  = ACK_HANDSHAKE,
   parameter logic [NUM_CH*DATA_W-1:0]  RESET_VAL = '0
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [NUM_CH*DATA_W-1:0] reg_wdata_i,
   input  logic [NUM_CH-1:0]        reg_we_i,
   output logic [NUM_CH*DATA_W-1:0] reg_rdata_o,
   output logic [NUM_CH-1:0]        reg_rvalid_o,
   output logic [NUM_CH*DATA_W-1:0] ip_data_o,
   output logic [NUM_CH-1:0]        ip_req_o,
   input  logic [NUM_CH-1:0]        ip_ack_i,
   input  logic [NUM_CH*DATA_W-1:0] ip_wdata_i,
   input  logic [NUM_CH-1:0]        ip_we_i,
   output logic [NUM_CH-1:0]        ovf_o,
   input  logic [NUM_CH-1:0]        ovf_clr_i
);

   logic [NUM_CH*DATA_W-1:0] ch_s;

   if (NUM_CH < 1 || NUM_CH > MAX_CH) begin : g_bad_num_ch
      $error("custom_ip_reg_bank: NUM_CH=%0d outside 1..%0d", NUM_CH, MAX_CH);
   end
   if (DATA_W < 1 || DATA_W > MAX_DATA_W) begin : g_bad_data_w
      $error("custom_ip_reg_bank: DATA_W=%0d outside 1..%0d", DATA_W, MAX_DATA_W);
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      custom_ip_reg_chan #(
         .DATA_W    (DATA_W),
         .ACK_MODE  (ACK_MODE),
         .RESET_VAL (RESET_VAL[c*DATA_W +: DATA_W])
      ) u_chan (
         .clk_i       (clk_i),
         .rst_i       (rst_i),
         .reg_wdata_i (reg_wdata_i[c*DATA_W +: DATA_W]),
         .reg_we_i    (reg_we_i[c]),
         .ip_wdata_i  (ip_wdata_i[c*DATA_W +: DATA_W]),
         .ip_we_i     (ip_we_i[c]),
         .ip_ack_i    (ip_ack_i[c]),
         .ovf_clr_i   (ovf_clr_i[c]),
         .ch_o        (ch_s[c*DATA_W +: DATA_W]),
         .rvalid_o    (reg_rvalid_o[c]),
         .req_o       (ip_req_o[c]),
         .ovf_o       (ovf_o[c])
      );
   end

   // Register file and IP see the very same flops.
   assign reg_rdata_o = ch_s;
   assign ip_data_o   = ch_s;

endmodule

// File: tb/tb_custom_ip_reg_bank.sv
// Directed bench for custom_ip_reg_bank: a handshake-mode bank with non-zero reset values
// and a pulse-mode bank; read-back data is scoreboarded against rvalid pulses.
module tb_custom_ip_reg_bank;
   import custom_ip_pkg::*;

   localparam logic [95:0] RV = {32'h0, 32'h0000CAFE, 32'h1};

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [95:0] wdata = '0, ip_wdata = '0, rdata, ipdata;
   logic [2:0]  we = '0, ip_we = '0, ack = '0, clr = '0, rvalid, req, ovf;
   logic [95:0] p_wdata = '0, p_rdata, p_ipdata;
   logic [2:0]  p_we = '0, p_ack = '0, p_rvalid, p_req, p_ovf;

   int checks = 0;
   int errors = 0;

   typedef struct packed { logic [1:0] ch; logic [31:0] data; } exp_t;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   custom_ip_reg_bank #(.NUM_CH(3), .DATA_W(32), .ACK_MODE(ACK_HANDSHAKE), .RESET_VAL(RV)) dut (
      .clk_i(clk), .rst_i(rst), .reg_wdata_i(wdata), .reg_we_i(we), .reg_rdata_o(rdata),
      .reg_rvalid_o(rvalid), .ip_data_o(ipdata), .ip_req_o(req), .ip_ack_i(ack),
      .ip_wdata_i(ip_wdata), .ip_we_i(ip_we), .ovf_o(ovf), .ovf_clr_i(clr));

   custom_ip_reg_bank #(.NUM_CH(3), .DATA_W(32), .ACK_MODE(ACK_PULSE), .RESET_VAL('0)) dut_p (
      .clk_i(clk), .rst_i(rst), .reg_wdata_i(p_wdata), .reg_we_i(p_we), .reg_rdata_o(p_rdata),
      .reg_rvalid_o(p_rvalid), .ip_data_o(p_ipdata), .ip_req_o(p_req), .ip_ack_i(p_ack),
      .ip_wdata_i(96'h0), .ip_we_i(3'b000), .ovf_o(p_ovf), .ovf_clr_i(3'b000));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Strobes are cleared shortly after each edge so every write lasts exactly one cycle.
   task automatic tick();
      @(posedge clk);
      #1;
      we = '0; ip_we = '0; ack = '0; clr = '0; p_we = '0; p_ack = '0;
      @(negedge clk);
   endtask

   task automatic wr(input int c, input logic [31:0] d);
      wdata[c*32 +: 32] = d;
      we[c] = 1'b1;
      exp_q.push_back('{ch: 2'(c), data: d});
   endtask

   // Monitor: every read-back valid must match the oldest expected update.
   always @(negedge clk) begin
      exp_t e;
      for (int c = 0; c < 3; c++) begin
         if (rvalid[c]) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL rvalid_unexpected ch%0d: got=1 expected=0 at %0t", c, $time);
            end else begin
               e = exp_q.pop_front();
               chk("rvalid_channel", 64'(c), 64'(e.ch));
               chk("rvalid_data", 64'(rdata[c*32 +: 32]), 64'(e.data));
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (2) @(negedge clk);
      rst = 1'b0;
      // reset values
      chk("reset_rdata", 64'(rdata[31:0]), 64'h1);
      chk("reset_rdata_ch1", 64'(rdata[63:32]), 64'hCAFE);
      chk("reset_rdata_ch2", 64'(rdata[95:64]), 64'h0);
      chk("reset_req_ovf_rv", {55'h0, req, ovf, rvalid}, 64'h0);
      chk("p_reset_req", 64'(p_req), 64'h0);

      // handshake with ack three cycles later
      wr(0, 32'hDEADBEEF); tick();
      chk("t2_rdata", 64'(rdata[31:0]), 64'hDEADBEEF);
      chk("t2_ipdata", 64'(ipdata[31:0]), 64'hDEADBEEF);
      chk("t2_req_n1", 64'(req[0]), 64'h1);
      tick();
      chk("t2_req_n2", 64'(req[0]), 64'h1);
      ack[0] = 1'b1;
      chk("t2_req_n3", 64'(req[0]), 64'h1);
      tick();
      chk("t2_req_n4", 64'(req[0]), 64'h0);

      // overrun, clear/set collision, ack+write, plain clear
      wr(1, 32'hA5A5A5A5); tick();
      chk("t3_req", 64'(req[1]), 64'h1);
      chk("t3_ovf0", 64'(ovf[1]), 64'h0);
      wr(1, 32'h5A5A5A5A); tick();
      chk("t3_data", 64'(rdata[63:32]), 64'h5A5A5A5A);
      chk("t3_ovf1", 64'(ovf[1]), 64'h1);
      chk("t3_req_held", 64'(req[1]), 64'h1);
      wr(1, 32'h12345678); clr[1] = 1'b1; tick();
      chk("t3_set_beats_clr", 64'(ovf[1]), 64'h1);
      clr[1] = 1'b1; tick();
      chk("t3_clr", 64'(ovf[1]), 64'h0);
      chk("t3_req_after_clr", 64'(req[1]), 64'h1);
      wr(1, 32'h0BADF00D); ack[1] = 1'b1; tick();
      chk("t3_ackwr_req", 64'(req[1]), 64'h1);
      chk("t3_ackwr_noovf", 64'(ovf[1]), 64'h0);
      ack[1] = 1'b1; tick();
      chk("t3_ack_idle", 64'(req[1]), 64'h0);

      // write priority, then IP-only write
      wr(2, 32'h11111111); ip_we[2] = 1'b1; ip_wdata[95:64] = 32'h22222222; tick();
      chk("t4_prio_data", 64'(rdata[95:64]), 64'h11111111);
      chk("t4_prio_req", 64'(req[2]), 64'h1);
      ip_we[2] = 1'b1; ip_wdata[95:64] = 32'h33333333;
      exp_q.push_back('{ch: 2'd2, data: 32'h33333333});
      tick();
      chk("t4_ipwr_data", 64'(rdata[95:64]), 64'h33333333);
      chk("t4_ipwr_req", 64'(req[2]), 64'h1);
      ack[2] = 1'b1; tick();
      chk("t4_ack_req", 64'(req[2]), 64'h0);

      // pulse mode: back-to-back writes with ack held
      for (int i = 0; i < 3; i++) begin
         p_we[0] = 1'b1; p_ack[0] = 1'b1; p_wdata[31:0] = 32'hC0DE0000 + 32'(i);
         tick();
         chk("t5_req_pulse", 64'(p_req[0]), 64'h1);
         chk("t5_rvalid", 64'(p_rvalid[0]), 64'h1);
         chk("t5_ovf", 64'(p_ovf[0]), 64'h0);
      end
      p_ack[0] = 1'b1; tick();
      chk("t5_req_end", 64'(p_req[0]), 64'h0);
      chk("t5_data", 64'(p_rdata[31:0]), 64'hC0DE0002);

      // reset mid-handshake, late ack ignored
      wr(1, 32'hFEEDFACE); tick();
      chk("t6_req_before", 64'(req[1]), 64'h1);
      #2 rst = 1'b1;
      #1;
      chk("t6_req_async", 64'(req[1]), 64'h0);
      chk("t6_data_reset", 64'(rdata[63:32]), 64'hCAFE);
      @(posedge clk); @(negedge clk);
      rst = 1'b0;
      ack[1] = 1'b1; tick();
      chk("t6_late_ack", 64'(req[1]), 64'h0);
      chk("t6_ovf", 64'(ovf), 64'h0);
      tick();

      chk("scoreboard_drained", 64'(exp_q.size()), 64'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
